// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline boundary: valid/ready handshake, NUM_WR register-write lanes
// plus a HI/LO group, one-entry skid buffer and synchronous flush.
module mem_wb_pipe #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int NUM_WR        = 2,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [NUM_WR*ADDR_W-1:0]   mem_wd,
    input  logic [NUM_WR-1:0]          mem_wreg,
    input  logic [NUM_WR*DATA_W-1:0]   mem_wdata,
    input  logic                       mem_whilo,
    input  logic [DATA_W-1:0]          mem_hi,
    input  logic [DATA_W-1:0]          mem_lo,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [NUM_WR*ADDR_W-1:0]   wb_wd,
    output logic [NUM_WR-1:0]          wb_wreg,
    output logic [NUM_WR*DATA_W-1:0]   wb_wdata,
    output logic                       wb_whilo,
    output logic [DATA_W-1:0]          wb_hi,
    output logic [DATA_W-1:0]          wb_lo
);

    // Writes to register 0 are dropped at capture so writeback never sees them.
    function automatic logic [NUM_WR-1:0] filter_wreg(
        input logic [NUM_WR*ADDR_W-1:0] wd,
        input logic [NUM_WR-1:0]        wreg
    );
        logic [NUM_WR-1:0] r;
        for (int i = 0; i < NUM_WR; i++)
            r[i] = wreg[i] & ~((ZERO_SUPPRESS != 0) && (wd[i*ADDR_W +: ADDR_W] == '0));
        return r;
    endfunction

    logic [NUM_WR-1:0]        wreg_p0;
    logic                     accept_p0;
    logic                     drain_p0;

    logic                     vld_p1;
    logic [NUM_WR*ADDR_W-1:0] wd_p1;
    logic [NUM_WR-1:0]        wreg_p1;
    logic [NUM_WR*DATA_W-1:0] wdata_p1;
    logic                     whilo_p1;
    logic [DATA_W-1:0]        hi_p1;
    logic [DATA_W-1:0]        lo_p1;

    logic                     skd_vld_p1;
    logic [NUM_WR*ADDR_W-1:0] skd_wd_p1;
    logic [NUM_WR-1:0]        skd_wreg_p1;
    logic [NUM_WR*DATA_W-1:0] skd_wdata_p1;
    logic                     skd_whilo_p1;
    logic [DATA_W-1:0]        skd_hi_p1;
    logic [DATA_W-1:0]        skd_lo_p1;

    // ---- stage p0: capture filtering and handshake decode ----
    assign mem_ready = ~skd_vld_p1;
    assign wreg_p0   = filter_wreg(mem_wd, mem_wreg);
    assign accept_p0 = mem_valid & mem_ready;
    assign drain_p0  = vld_p1 & wb_ready;

    // ---- stage p1: output register and skid register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            wd_p1        <= '0;
            wreg_p1      <= '0;
            wdata_p1     <= '0;
            whilo_p1     <= 1'b0;
            hi_p1        <= '0;
            lo_p1        <= '0;
            skd_vld_p1   <= 1'b0;
            skd_wd_p1    <= '0;
            skd_wreg_p1  <= '0;
            skd_wdata_p1 <= '0;
            skd_whilo_p1 <= 1'b0;
            skd_hi_p1    <= '0;
            skd_lo_p1    <= '0;
        end else if (flush) begin
            vld_p1     <= 1'b0;
            wreg_p1    <= '0;
            whilo_p1   <= 1'b0;
            skd_vld_p1 <= 1'b0;
        end else if (!skd_vld_p1) begin
            if (accept_p0 && (!vld_p1 || drain_p0)) begin
                vld_p1   <= 1'b1;
                wd_p1    <= mem_wd;
                wreg_p1  <= wreg_p0;
                wdata_p1 <= mem_wdata;
                whilo_p1 <= mem_whilo;
                hi_p1    <= mem_hi;
                lo_p1    <= mem_lo;
            end else if (accept_p0) begin
                skd_vld_p1   <= 1'b1;
                skd_wd_p1    <= mem_wd;
                skd_wreg_p1  <= wreg_p0;
                skd_wdata_p1 <= mem_wdata;
                skd_whilo_p1 <= mem_whilo;
                skd_hi_p1    <= mem_hi;
                skd_lo_p1    <= mem_lo;
            end else if (drain_p0) begin
                // Empty output must not expose a stale write-enable.
                vld_p1   <= 1'b0;
                wreg_p1  <= '0;
                whilo_p1 <= 1'b0;
            end
        end else if (drain_p0) begin
            skd_vld_p1 <= 1'b0;
            wd_p1      <= skd_wd_p1;
            wreg_p1    <= skd_wreg_p1;
            wdata_p1   <= skd_wdata_p1;
            whilo_p1   <= skd_whilo_p1;
            hi_p1      <= skd_hi_p1;
            lo_p1      <= skd_lo_p1;
        end
    end

    assign wb_valid = vld_p1;
    assign wb_wd    = wd_p1;
    assign wb_wreg  = wreg_p1;
    assign wb_wdata = wdata_p1;
    assign wb_whilo = whilo_p1;
    assign wb_hi    = hi_p1;
    assign wb_lo    = lo_p1;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: stimulus pushes expected beats, a monitor
// pops and compares on every writeback drain.
module tb_mem_wb_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_WR = 2;

    typedef struct packed {
        logic [NUM_WR*ADDR_W-1:0] wd;
        logic [NUM_WR-1:0]        wreg;
        logic [NUM_WR*DATA_W-1:0] wdata;
        logic                     whilo;
        logic [DATA_W-1:0]        hi;
        logic [DATA_W-1:0]        lo;
    } beat_t;

    logic clk = 1'b0;
    logic rst, flush, mem_valid, wb_ready;
    logic mem_ready, wb_valid;
    logic [NUM_WR*ADDR_W-1:0] mem_wd, wb_wd;
    logic [NUM_WR-1:0]        mem_wreg, wb_wreg;
    logic [NUM_WR*DATA_W-1:0] mem_wdata, wb_wdata;
    logic                     mem_whilo, wb_whilo;
    logic [DATA_W-1:0]        mem_hi, mem_lo, wb_hi, wb_lo;

    logic z0_mem_ready, z0_wb_valid, z0_wb_whilo;
    logic [NUM_WR*ADDR_W-1:0] z0_wb_wd;
    logic [NUM_WR-1:0]        z0_wb_wreg;
    logic [NUM_WR*DATA_W-1:0] z0_wb_wdata;
    logic [DATA_W-1:0]        z0_wb_hi, z0_wb_lo;

    int total = 0;
    int bad   = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_SUPPRESS(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
        .wb_hi(wb_hi), .wb_lo(wb_lo)
    );

    mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_SUPPRESS(0)) dut_z0 (
        .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(z0_mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .wb_valid(z0_wb_valid), .wb_ready(wb_ready),
        .wb_wd(z0_wb_wd), .wb_wreg(z0_wb_wreg), .wb_wdata(z0_wb_wdata), .wb_whilo(z0_wb_whilo),
        .wb_hi(z0_wb_hi), .wb_lo(z0_wb_lo)
    );

    function automatic beat_t mk(input logic [4:0] wd0, input logic [4:0] wd1, input logic [1:0] wreg,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic whilo,
                                 input logic [31:0] hi, input logic [31:0] lo);
        beat_t b;
        b.wd    = {wd1, wd0};
        b.wreg  = wreg;
        b.wdata = {d1, d0};
        b.whilo = whilo;
        b.hi    = hi;
        b.lo    = lo;
        return b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input beat_t b);
        mem_wd    = b.wd;
        mem_wreg  = b.wreg;
        mem_wdata = b.wdata;
        mem_whilo = b.whilo;
        mem_hi    = b.hi;
        mem_lo    = b.lo;
    endtask

    // Offer a beat until accepted; the expected writeback beat is queued at accept.
    task automatic send(input beat_t b, input beat_t exp);
        bit done = 0;
        drive(b);
        mem_valid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                q.push_back(exp);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        mem_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got=not accepted expected=accepted");
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            beat_t act, exp;
            act = {wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got=%0h expected=none", act);
            end else begin
                exp = q.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL beat: got=%0h expected=%0h", act, exp);
                end
            end
        end
    end

    beat_t a, b, c, d, z, zexp, h;

    initial begin
        rst = 1'b1; flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b1;
        mem_wd = '0; mem_wreg = '0; mem_wdata = '0; mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
        a = mk(5'd3, 5'd7, 2'b11, 32'h11, 32'h22, 1'b0, 32'h0, 32'h0);
        b = mk(5'd5, 5'd9, 2'b01, 32'h33, 32'h44, 1'b0, 32'h0, 32'h0);
        c = mk(5'd1, 5'd2, 2'b10, 32'h55, 32'h66, 1'b1, 32'hA, 32'hB);
        d = mk(5'd6, 5'd8, 2'b11, 32'h77, 32'h88, 1'b1, 32'hC, 32'hD);
        z = mk(5'd0, 5'd4, 2'b11, 32'h99, 32'hAA, 1'b0, 32'h0, 32'h0);
        zexp = z; zexp.wreg = 2'b10;
        h = mk(5'd10, 5'd11, 2'b00, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF, 32'h12345678);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_mem_ready", mem_ready, 1);
        check("reset_outputs", {wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo}, 0);
        @(posedge clk); #1;

        // Streaming, wb_ready=1
        fork
            begin send(a, a); send(b, b); end
            begin
                @(negedge clk);
                @(negedge clk);
                check("stream_lat_a", {wb_valid, mem_ready, wb_wd}, {1'b1, 1'b1, a.wd});
                @(negedge clk);
                check("stream_lat_b", {wb_valid, mem_ready, wb_wd}, {1'b1, 1'b1, b.wd});
            end
        join
        repeat (3) @(posedge clk); #1;
        check("stream_drained", q.size(), 0);

        // Back-pressure with skid
        wb_ready = 1'b0;
        send(a, a);
        send(b, b);
        fork
            send(c, c);
            begin
                @(negedge clk);
                check("bp_mem_ready_low", mem_ready, 0);
                check("bp_out_holds_a", {wb_valid, wb_wd, wb_wdata}, {1'b1, a.wd, a.wdata});
                @(posedge clk); #1;
                @(negedge clk);
                check("bp_still_held", {wb_valid, wb_wd, mem_ready}, {1'b1, a.wd, 1'b0});
                @(posedge clk); #1;
                wb_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        check("bp_all_drained", q.size(), 0);
        check("bp_mem_ready_back", mem_ready, 1);

        // Zero suppress, both parameterisations
        send(z, zexp);
        @(negedge clk);
        check("zs1_wreg", wb_wreg, 2'b10);
        check("zs0_wreg", z0_wb_wreg, 2'b11);
        @(posedge clk); #1;

        // HI/LO group
        send(h, h);
        @(negedge clk);
        check("hilo_vals", {wb_whilo, wb_hi, wb_lo}, {1'b1, 32'hDEADBEEF, 32'h12345678});
        @(negedge clk);
        check("hilo_cleared", {wb_valid, wb_whilo, wb_wreg}, 0);
        @(posedge clk); #1;

        // Flush with OUT and SKD full and a beat offered
        wb_ready = 1'b0;
        send(a, a);
        send(b, b);
        drive(d);
        mem_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        mem_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check("flush_state", {wb_valid, wb_wreg, wb_whilo, mem_ready}, {1'b0, 2'b00, 1'b0, 1'b1});
        wb_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("flush_no_beat", wb_valid, 0);

        // Reset mid-stall with SKD full
        wb_ready = 1'b0;
        send(c, c);
        send(d, d);
        @(negedge clk);
        check("stall_full", {wb_valid, mem_ready}, {1'b1, 1'b0});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrst_outputs", {wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo}, 0);
        check("midrst_hilo", {wb_hi, wb_lo}, 0);
        check("midrst_ready", {mem_ready, z0_mem_ready, z0_wb_valid}, 3'b110);
        wb_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
